// File: rtl/data_memory_bytelane_if.sv
// CPU load/store bus and halted-CPU debug port of the byte-lane data memory.
// The master side is the MEM stage / debug controller; the slave side is the memory.
interface data_memory_bytelane_if #(
    parameter int DBG_ADDR_W = 9
);
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
    logic [31:0]           address;
    logic [31:0]           write_data;
    logic [31:0]           read_data;
    logic                  misaligned;
    logic                  busy;
    logic                  cpu_enable;
    logic                  dbg_req;
    logic                  dbg_rw;
    logic [DBG_ADDR_W-1:0] dbg_addr;
    logic [31:0]           dbg_wdata;
    logic                  dbg_ack;
    logic [31:0]           dbg_rdata;
    logic [31:0]           data_mem0;

    modport master (
        output mem_read, mem_write, funct3, address, write_data,
        output cpu_enable, dbg_req, dbg_rw, dbg_addr, dbg_wdata,
        input  read_data, misaligned, busy, dbg_ack, dbg_rdata, data_mem0
    );

    modport slave (
        input  mem_read, mem_write, funct3, address, write_data,
        input  cpu_enable, dbg_req, dbg_rw, dbg_addr, dbg_wdata,
        output read_data, misaligned, busy, dbg_ack, dbg_rdata, data_mem0
    );
endinterface

// File: rtl/data_memory_bytelane.sv
// Word-organised data memory for the RV32I MEM stage: byte-lane stores,
// sign/zero-extending loads, misalignment detection, post-reset clear and
// a req/ack debug port that is serviced only while the CPU is halted.
module data_memory_bytelane #(
    parameter int DEPTH          = 1024,
    parameter int DBG_ADDR_W     = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    data_memory_bytelane_if.slave  bus
);
    localparam int ADDR_BITS = $clog2(DEPTH);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ADDR_BITS-1:0] clear_idx;
    logic [31:0]          mem [DEPTH];

    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane;
    logic [31:0]          cur_word;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic                 fmt_bad;
    logic                 misaligned_c;
    logic [3:0]           store_mask;
    logic [31:0]          store_data;
    logic                 store_en;

    logic [ADDR_BITS+DBG_ADDR_W-1:0] dbg_ext;
    logic [ADDR_BITS-1:0] dbg_idx;
    logic                 dbg_service;
    logic                 dbg_ack_q;
    logic [31:0]          dbg_rdata_q;

    // Upper address bits are deliberately ignored so accesses wrap modulo DEPTH.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.address[31:ADDR_BITS+2],
                           dbg_ext[ADDR_BITS+DBG_ADDR_W-1:ADDR_BITS]};

    assign word_idx = bus.address[ADDR_BITS+1:2];
    assign lane     = bus.address[1:0];
    assign cur_word = mem[word_idx];

    // Debug index is the debug address zero-extended, then cut to ADDR_BITS.
    assign dbg_ext  = {{ADDR_BITS{1'b0}}, bus.dbg_addr};
    assign dbg_idx  = dbg_ext[ADDR_BITS-1:0];

    // State register and clear index; reset restarts the clear from word 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clear_idx <= '0;
        end else begin
            state <= state_next;
            if (state == ST_CLEAR) begin
                clear_idx <= clear_idx + 1'b1;
            end
        end
    end

    // Next-state: leave CLEAR after the last word has been zeroed.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            ST_CLEAR: if (clear_idx == ADDR_BITS'(DEPTH - 1)) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_READY;
        endcase
    end

    // Size/format check: unsupported funct3 codes also count as misaligned.
    always_comb begin
        fmt_bad = 1'b1;
        case (bus.funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: fmt_bad = 1'b0;
            default:                                fmt_bad = 1'b1;
        endcase
        misaligned_c = (bus.mem_read || bus.mem_write) &&
                       (fmt_bad ||
                        (bus.funct3[1:0] == 2'b01 && bus.address[0]) ||
                        (bus.funct3[1:0] == 2'b10 && lane != 2'b00));
    end

    // Combinational load path with sign/zero extension; zero when idle or blocked.
    always_comb begin
        byte_sel      = cur_word[{lane, 3'b000} +: 8];
        half_sel      = bus.address[1] ? cur_word[31:16] : cur_word[15:0];
        bus.read_data = '0;
        if (state == ST_READY && bus.mem_read && !misaligned_c) begin
            case (bus.funct3[1:0])
                2'b00:   bus.read_data = bus.funct3[2] ? {24'b0, byte_sel}
                                                       : {{24{byte_sel[7]}}, byte_sel};
                2'b01:   bus.read_data = bus.funct3[2] ? {16'b0, half_sel}
                                                       : {{16{half_sel[15]}}, half_sel};
                2'b10:   bus.read_data = cur_word;
                default: bus.read_data = '0;
            endcase
        end
    end

    // Store lane mask and replicated data so each lane sees its own bits.
    always_comb begin
        store_mask = 4'b0000;
        store_data = bus.write_data;
        case (bus.funct3[1:0])
            2'b00: begin
                store_mask = 4'b0001 << lane;
                store_data = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                store_mask = bus.address[1] ? 4'b1100 : 4'b0011;
                store_data = {2{bus.write_data[15:0]}};
            end
            2'b10:   store_mask = 4'b1111;
            default: store_mask = 4'b0000;
        endcase
    end

    assign store_en    = (state == ST_READY) && bus.mem_write && !misaligned_c && !reset;
    // A CPU store in the same cycle, or a pending ack, defers the debug op.
    assign dbg_service = (state == ST_READY) && !bus.cpu_enable && bus.dbg_req &&
                         !bus.mem_write && !dbg_ack_q;

    // Memory write port: clear, then CPU store, then debug write, in priority order.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; zeroing it is the job of the CLEAR sequence.
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clear_idx] <= '0;
            end else if (store_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (store_mask[b]) begin
                        mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
                    end
                end
            end else if (dbg_service && bus.dbg_rw) begin
                mem[dbg_idx] <= bus.dbg_wdata;
            end
        end
    end

    // Debug completion pulse and read data capture (pre-write value).
    always_ff @(posedge clk) begin
        if (reset) begin
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            dbg_ack_q <= dbg_service;
            if (dbg_service && !bus.dbg_rw) begin
                dbg_rdata_q <= mem[dbg_idx];
            end
        end
    end

    assign bus.misaligned = misaligned_c;
    assign bus.busy       = (state == ST_CLEAR);
    assign bus.dbg_ack    = dbg_ack_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.data_mem0  = mem[0];
endmodule
